// File: rtl/attack_controller_if.sv
// Player I/O bundle: raw buttons and collision inputs in, attack status and damage pulse out.
// Latency: none, wires only.
// Backpressure: none; the damage pulse is fire-and-forget toward the health stage.
interface attack_controller_if;
    logic       btn_punch;
    logic       btn_kick;
    logic       btn_block;
    logic       in_range;
    logic       opp_blocking;
    logic [1:0] attack_state;
    logic       busy;
    logic       damage_valid;
    logic [3:0] damage_amt;

    // Controller side
    modport slave (
        input  btn_punch, btn_kick, btn_block, in_range, opp_blocking,
        output attack_state, busy, damage_valid, damage_amt
    );

    // Stimulus / upstream side
    modport master (
        output btn_punch, btn_kick, btn_block, in_range, opp_blocking,
        input  attack_state, busy, damage_valid, damage_amt
    );
endinterface

// File: rtl/attack_controller.sv
// Per-player attack sequencer: sync buttons, run windup/active/recover on the game tick, pulse damage.
// Latency: buttons reach the FSM after 2 clk sync plus the next tick; damage pulse is 1 clk after the hit tick.
// Backpressure: none; presses outside IDLE are dropped. Optional CHIP_DAMAGE_EN adds chip damage on blocked hits.
module attack_controller #(
    parameter int unsigned WINDUP_TICKS  = 2,
    parameter int unsigned ACTIVE_TICKS  = 2,
    parameter int unsigned RECOVER_TICKS = 4,
    parameter int unsigned PUNCH_DMG     = 5,
    parameter int unsigned KICK_DMG      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    attack_controller_if.slave io
);

    localparam logic [3:0] WINDUP_LAST  = 4'(WINDUP_TICKS - 1);
    localparam logic [3:0] ACTIVE_LAST  = 4'(ACTIVE_TICKS - 1);
    localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_TICKS - 1);
    localparam logic [3:0] PUNCH_AMT    = 4'(PUNCH_DMG);
    localparam logic [3:0] KICK_AMT     = 4'(KICK_DMG);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PUNCH = 2'b01;
    localparam logic [1:0] ST_KICK  = 2'b10;
    localparam logic [1:0] ST_BLOCK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        BLOCK,
        WINDUP,
        ACTIVE,
        RECOVER
    } fsm_t;

    fsm_t       state;
    logic [3:0] cnt;
    logic       hit_done;
    logic [1:0] kind;

    // Bit order {block, kick, punch}
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] prev;

    logic       blk_held;
    logic       kick_press;
    logic       punch_press;
    logic [3:0] base_dmg;

    assign blk_held    = sync2[2];
    assign kick_press  = sync2[1] & ~prev[1];
    assign punch_press = sync2[0] & ~prev[0];
    assign base_dmg    = (kind == ST_KICK) ? KICK_AMT : PUNCH_AMT;

`ifdef CHIP_DAMAGE_EN
    logic [3:0] chip_dmg;
    assign chip_dmg = base_dmg >> 2;
`endif

    // Two-flop synchroniser for the raw asynchronous buttons
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= {io.btn_block, io.btn_kick, io.btn_punch};
            sync2 <= sync1;
        end
    end

    // Attack FSM with registered status outputs; everything but the pulse moves only on tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            hit_done        <= 1'b0;
            kind            <= ST_PUNCH;
            prev            <= 3'b000;
            io.attack_state <= ST_IDLE;
            io.busy         <= 1'b0;
            io.damage_valid <= 1'b0;
            io.damage_amt   <= 4'd0;
        end else begin
            io.damage_valid <= 1'b0;
            io.damage_amt   <= 4'd0;
            if (tick) begin
                prev <= sync2;
                case (state)
                    IDLE: begin
                        if (blk_held) begin
                            state           <= BLOCK;
                            io.attack_state <= ST_BLOCK;
                            io.busy         <= 1'b1;
                        end else if (kick_press || punch_press) begin
                            state           <= WINDUP;
                            cnt             <= 4'd0;
                            kind            <= kick_press ? ST_KICK : ST_PUNCH;
                            io.attack_state <= kick_press ? ST_KICK : ST_PUNCH;
                            io.busy         <= 1'b1;
                        end
                    end
                    BLOCK: begin
                        if (!blk_held) begin
                            state           <= IDLE;
                            io.attack_state <= ST_IDLE;
                            io.busy         <= 1'b0;
                        end
                    end
                    WINDUP: begin
                        if (cnt == WINDUP_LAST) begin
                            state    <= ACTIVE;
                            cnt      <= 4'd0;
                            hit_done <= 1'b0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    ACTIVE: begin
                        // Only the first in-range tick of the window counts as the hit
                        if (io.in_range && !hit_done) begin
                            hit_done <= 1'b1;
                            if (!io.opp_blocking) begin
                                io.damage_valid <= 1'b1;
                                io.damage_amt   <= base_dmg;
                            end
`ifdef CHIP_DAMAGE_EN
                            else if (chip_dmg != 4'd0) begin
                                io.damage_valid <= 1'b1;
                                io.damage_amt   <= chip_dmg;
                            end
`endif
                        end
                        if (cnt == ACTIVE_LAST) begin
                            state <= RECOVER;
                            cnt   <= 4'd0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    RECOVER: begin
                        if (cnt == RECOVER_LAST) begin
                            state           <= IDLE;
                            cnt             <= 4'd0;
                            io.attack_state <= ST_IDLE;
                            io.busy         <= 1'b0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    default: begin
                        state           <= IDLE;
                        cnt             <= 4'd0;
                        io.attack_state <= ST_IDLE;
                        io.busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_attack_controller.sv
// Bench for attack_controller: tick-level behavioural model, per-cycle compare, directed and random stimulus.
// Latency: model predicts outputs for the clk cycle following each tick.
// Backpressure: not applicable.
module tb_attack_controller;

    localparam int W  = 2;
    localparam int A  = 2;
    localparam int R  = 4;
    localparam int PD = 5;
    localparam int KD = 8;

    logic clk = 1'b0;
    logic reset;
    logic tick;

    always #5 clk = ~clk;

    attack_controller_if io();

    attack_controller #(
        .WINDUP_TICKS (W),
        .ACTIVE_TICKS (A),
        .RECOVER_TICKS(R),
        .PUNCH_DMG    (PD),
        .KICK_DMG     (KD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .tick (tick),
        .io   (io)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int tick_cnt = 0;

    // Model state: mode 0 idle, 1 block, 2 attack; m_t = ticks elapsed inside the attack
    int         m_mode;
    logic [1:0] m_kind;
    int         m_t;
    bit         m_hit;
    bit         m_pp;
    bit         m_pk;

    logic [1:0] exp_state;
    logic       exp_busy;
    logic       exp_dv;
    logic [3:0] exp_amt;

    // Observed pulses
    int dut_pulses = 0;
    int dut_last_amt = 0;
    int dut_last_tick = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_kind = 2'b01; m_t = 0; m_hit = 0; m_pp = 0; m_pk = 0;
        exp_state = 2'b00; exp_busy = 1'b0; exp_dv = 1'b0; exp_amt = 4'd0;
    endtask

    task automatic model_tick(input bit p, input bit k, input bit b, input bit ir, input bit ob);
        bit pp;
        bit pk;
        int base;
        pp = p && !m_pp;
        pk = k && !m_pk;
        exp_dv = 1'b0;
        exp_amt = 4'd0;
        case (m_mode)
            0: begin
                if (b) m_mode = 1;
                else if (pk) begin m_mode = 2; m_kind = 2'b10; m_t = 0; m_hit = 0; end
                else if (pp) begin m_mode = 2; m_kind = 2'b01; m_t = 0; m_hit = 0; end
            end
            1: if (!b) m_mode = 0;
            default: begin
                m_t++;
                if (m_t > W && m_t <= W + A && ir && !m_hit) begin
                    m_hit = 1;
                    base = (m_kind == 2'b10) ? KD : PD;
                    if (!ob) begin
                        exp_dv = 1'b1;
                        exp_amt = 4'(base);
                    end
`ifdef CHIP_DAMAGE_EN
                    else if (base / 4 != 0) begin
                        exp_dv = 1'b1;
                        exp_amt = 4'(base / 4);
                    end
`endif
                end
                if (m_t == W + A + R) m_mode = 0;
            end
        endcase
        m_pp = p;
        m_pk = k;
        exp_state = (m_mode == 0) ? 2'b00 : (m_mode == 1) ? 2'b11 : m_kind;
        exp_busy = (m_mode != 0);
    endtask

    // Per-cycle compare against the model, plus pulse monitor
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            checks++;
            if (io.attack_state !== exp_state || io.busy !== exp_busy ||
                io.damage_valid !== exp_dv || io.damage_amt !== exp_amt) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t: state=%b busy=%b dv=%b amt=%0d expected state=%b busy=%b dv=%b amt=%0d",
                         $time, io.attack_state, io.busy, io.damage_valid, io.damage_amt,
                         exp_state, exp_busy, exp_dv, exp_amt);
            end
            if (io.damage_valid === 1'b1) begin
                dut_pulses++;
                dut_last_amt = int'(io.damage_amt);
                dut_last_tick = tick_cnt;
            end
        end
    end

    // One game tick: drive inputs, let them settle through the synchroniser, then pulse tick
    task automatic do_tick(input bit p, input bit k, input bit b, input bit ir, input bit ob);
        io.btn_punch = p;
        io.btn_kick = k;
        io.btn_block = b;
        io.in_range = ir;
        io.opp_blocking = ob;
        repeat ($urandom_range(2, 4)) @(negedge clk);
        tick = 1'b1;
        tick_cnt++;
        model_tick(p, k, b, ir, ob);
        @(negedge clk);
        tick = 1'b0;
        exp_dv = 1'b0;
        exp_amt = 4'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_async_state", int'(io.attack_state), 0);
        chk("rst_async_busy", int'(io.busy), 0);
        chk("rst_async_dv", int'(io.damage_valid), 0);
        chk("rst_async_amt", int'(io.damage_amt), 0);
        io.btn_punch = 0; io.btn_kick = 0; io.btn_block = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t0;
        int cnt;
        bit p, k, b;
        reset = 1'b0;
        tick = 1'b0;
        io.btn_punch = 0; io.btn_kick = 0; io.btn_block = 0;
        io.in_range = 0; io.opp_blocking = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state", int'(io.attack_state), 0);
        chk("reset_busy", int'(io.busy), 0);
        chk("reset_dv", int'(io.damage_valid), 0);
        chk("reset_amt", int'(io.damage_amt), 0);
        chk_en = 1;
        reset = 1'b1;
        @(negedge clk);

        // Punch landing on an unblocked opponent
        base = dut_pulses;
        cnt = 0;
        do_tick(1, 0, 0, 1, 0);
        t0 = tick_cnt;
        chk("punch_state", int'(io.attack_state), 1);
        cnt += (io.attack_state == 2'b01) ? 1 : 0;
        for (int i = 1; i <= 8; i++) begin
            do_tick(0, 0, 0, 1, 0);
            cnt += (io.attack_state == 2'b01) ? 1 : 0;
        end
        chk("punch_len", cnt, 8);
        chk("punch_pulses", dut_pulses - base, 1);
        chk("punch_amt", dut_last_amt, 5);
        chk("punch_pulse_tick", dut_last_tick - t0, 3);
        chk("punch_busy_end", int'(io.busy), 0);

        // Kick beats punch on the same tick; block beats kick
        base = dut_pulses;
        do_tick(1, 1, 0, 1, 0);
        chk("kick_prio_state", int'(io.attack_state), 2);
        for (int i = 0; i < 8; i++) do_tick(0, 0, 0, 1, 0);
        chk("kick_pulses", dut_pulses - base, 1);
        chk("kick_amt", dut_last_amt, 8);
        base = dut_pulses;
        do_tick(0, 1, 1, 1, 0);
        chk("block_prio_state", int'(io.attack_state), 3);
        do_tick(0, 0, 0, 1, 0);
        chk("block_release_state", int'(io.attack_state), 0);
        for (int i = 0; i < 4; i++) do_tick(0, 0, 0, 1, 0);
        chk("block_no_attack", dut_pulses - base, 0);

        // Held punch does not retrigger; release + re-press does
        base = dut_pulses;
        for (int i = 0; i < 20; i++) do_tick(1, 0, 0, 1, 0);
        chk("held_pulses", dut_pulses - base, 1);
        chk("held_busy", int'(io.busy), 0);
        do_tick(0, 0, 0, 1, 0);
        do_tick(1, 0, 0, 1, 0);
        chk("repress_state", int'(io.attack_state), 1);
        for (int i = 0; i < 8; i++) do_tick(0, 0, 0, 1, 0);
        chk("repress_pulses", dut_pulses - base, 2);

        // in_range toggling inside the window yields one hit
        base = dut_pulses;
        do_tick(0, 1, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 1, 0);
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) do_tick(0, 0, 0, 1, 0);
        chk("toggle_pulses", dut_pulses - base, 1);
        base = dut_pulses;
        do_tick(0, 1, 0, 0, 0);
        t0 = tick_cnt;
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) do_tick(0, 0, 0, 1, 0);
        chk("late_hit_pulses", dut_pulses - base, 1);
        chk("late_hit_tick", dut_last_tick - t0, 4);

        // Kick into a blocking opponent
        base = dut_pulses;
        do_tick(0, 1, 0, 1, 1);
        for (int i = 0; i < 8; i++) do_tick(0, 0, 0, 1, 1);
`ifdef CHIP_DAMAGE_EN
        chk("blocked_pulses", dut_pulses - base, 1);
        chk("blocked_chip_amt", dut_last_amt, 2);
`else
        chk("blocked_pulses", dut_pulses - base, 0);
`endif

        // Press during RECOVER is dropped; block held for 5 ticks
        base = dut_pulses;
        do_tick(1, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) do_tick(i == 6, 0, 0, 1, 0);
        chk("recover_drop_busy", int'(io.busy), 0);
        for (int i = 0; i < 3; i++) do_tick(0, 0, 0, 1, 0);
        chk("recover_drop_pulses", dut_pulses - base, 1);
        chk("recover_drop_idle", int'(io.busy), 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            do_tick(0, 0, 1, 0, 0);
            cnt += (io.attack_state == 2'b11) ? 1 : 0;
        end
        do_tick(0, 0, 0, 0, 0);
        chk("block_len", cnt, 5);
        chk("block_end_state", int'(io.attack_state), 0);

        // Reset during ACTIVE with in_range high aborts the attack
        base = dut_pulses;
        do_tick(1, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0);
        chk("pre_reset_busy", int'(io.busy), 1);
        io.in_range = 1;
        do_reset();
        for (int i = 0; i < 6; i++) do_tick(0, 0, 0, 1, 0);
        chk("post_reset_pulses", dut_pulses - base, 0);
        chk("post_reset_busy", int'(io.busy), 0);

        // Randomised play with persistent buttons and occasional resets
        p = 0; k = 0; b = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) p = ~p;
            if ($urandom_range(0, 3) == 0) k = ~k;
            if ($urandom_range(0, 7) == 0) b = ~b;
            do_tick(p, k, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
                p = 0; k = 0; b = 0;
            end
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
